// File: rtl/e603_icb_sram_pkg.sv
// Shared types and constants for the banked ICB SRAM slave and its response queue.
// Module parameters default to the P_* values here; the entry layout is sized from them.
package e603_icb_sram_pkg;

  localparam int P_AW          = 29;
  localparam int P_DW          = 32;
  localparam int P_BANKS       = 2;
  localparam int P_BANK_AW     = 12;
  localparam int P_DELAY_WIDTH = 9;
  localparam int P_OUTS        = 4;

  localparam int MW         = P_DW / 8;
  localparam int BANK_IDX_W = (P_BANKS > 1) ? $clog2(P_BANKS) : 1;
  localparam int PTR_W      = $clog2(P_OUTS);

  localparam logic ICB_ERR_OK     = 1'b0;
  localparam logic ICB_ERR_DECODE = 1'b1;

  typedef struct packed {
    logic                     read;
    logic                     err;
    logic [BANK_IDX_W-1:0]    bank;
    logic [P_DW-1:0]          rdata;
    logic                     dvld;
    logic [P_DELAY_WIDTH-1:0] cnt;
  } rsp_ent_t;

endpackage

// File: rtl/e603_icb_sram_rspq.sv
// In-order response FIFO: captures bank read data one cycle after push, counts down the emulated delay.
// Head is ready from push+1+delay; stalls simply hold the head, countdowns keep running.
module e603_icb_sram_rspq
  import e603_icb_sram_pkg::*;
#(
  parameter int DW    = P_DW,
  parameter int BANKS = P_BANKS,
  parameter int OUTS  = P_OUTS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  rsp_ent_t            i_push_ent,
  input  logic                i_pop,
  input  logic [BANKS*DW-1:0] i_bank_rdata,
  output logic                o_head_rdy,
  output logic [DW-1:0]       o_head_rdata,
  output logic                o_head_err
);

  rsp_ent_t         r_ent [OUTS];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_cap_ptr;
  logic             r_cap_vld;
  logic             w_cap_head;
  logic [DW-1:0]    w_cap_dat;

  always_comb begin
    w_cap_dat = '0;
    if (r_ent[r_cap_ptr].read && !r_ent[r_cap_ptr].err)
      w_cap_dat = i_bank_rdata[int'(r_ent[r_cap_ptr].bank) * DW +: DW];
  end

  // The entry pushed last cycle is readable straight from the macro output, so delay 0 answers at T+1.
  assign w_cap_head   = r_cap_vld & (r_cap_ptr == r_rptr);
  assign o_head_rdy   = (r_ent[r_rptr].dvld | w_cap_head) & (r_ent[r_rptr].cnt == '0);
  assign o_head_rdata = r_ent[r_rptr].dvld ? r_ent[r_rptr].rdata : w_cap_dat;
  assign o_head_err   = r_ent[r_rptr].err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTS; i++) r_ent[i] <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cap_ptr <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      for (int i = 0; i < OUTS; i++)
        if (r_ent[i].cnt != '0) r_ent[i].cnt <= r_ent[i].cnt - 1'b1;
      if (r_cap_vld) begin
        r_ent[r_cap_ptr].rdata <= w_cap_dat;
        r_ent[r_cap_ptr].dvld  <= 1'b1;
      end
      if (i_push) begin
        r_ent[r_wptr] <= i_push_ent;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      r_cap_vld <= i_push;
      r_cap_ptr <= r_wptr;
    end
  end

endmodule

// File: rtl/e603_icb_banked_sram.sv
// ICB slave over word-interleaved 1-cycle SRAM banks; bank pins driven combinationally on accept.
// Up to OUTS commands in flight; cmd_ready depends only on occupancy, never on rsp_ready.
module e603_icb_banked_sram
  import e603_icb_sram_pkg::*;
#(
  parameter int AW          = P_AW,
  parameter int DW          = P_DW,
  parameter int BANKS       = P_BANKS,
  parameter int BANK_AW     = P_BANK_AW,
  parameter int DELAY_WIDTH = P_DELAY_WIDTH,
  parameter int OUTS        = P_OUTS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DELAY_WIDTH-1:0] delay_select,
  input  logic                   icb_cmd_valid,
  output logic                   icb_cmd_ready,
  input  logic                   icb_cmd_read,
  input  logic [AW-1:0]          icb_cmd_addr,
  input  logic [DW-1:0]          icb_cmd_wdata,
  input  logic [DW/8-1:0]        icb_cmd_wmask,
  output logic                   icb_rsp_valid,
  input  logic                   icb_rsp_ready,
  output logic [DW-1:0]          icb_rsp_rdata,
  output logic                   icb_rsp_err,
  output logic [BANKS-1:0]       bank_cs,
  output logic                   bank_we,
  output logic [BANK_AW-1:0]     bank_addr,
  output logic [DW-1:0]          bank_wdata,
  output logic [DW/8-1:0]        bank_wem,
  input  logic [BANKS*DW-1:0]    bank_rdata
);

  localparam int WSH = $clog2(DW / 8);
  localparam int BSH = $clog2(BANKS);

  logic [AW-1:0]         w_word;
  logic [AW-1:0]         w_word_hi;
  logic [BANK_IDX_W-1:0] w_bank;
  logic                  w_oor;
  logic                  w_wr;
  logic                  w_acc;
  logic                  w_pop;
  logic                  w_cs_en;
  logic                  w_head_rdy;
  logic                  w_head_err;
  logic [DW-1:0]         w_head_rdata;
  rsp_ent_t              w_ent;
  logic [PTR_W:0]        r_occ;
  logic                  r_rdy_en;

  assign w_word    = icb_cmd_addr >> WSH;
  assign w_word_hi = w_word >> BSH;
  assign w_oor     = |(w_word_hi >> BANK_AW);
  assign w_bank    = w_word[BANK_IDX_W-1:0] & BANK_IDX_W'(BANKS - 1);
  assign w_wr      = ~icb_cmd_read;
  assign w_acc     = icb_cmd_valid & icb_cmd_ready;
  // A write with no byte enables is acknowledged without touching any macro.
  assign w_cs_en   = w_acc & ~w_oor & ~(w_wr & (icb_cmd_wmask == '0));

  assign bank_cs    = w_cs_en ? (BANKS'(1) << w_bank) : '0;
  assign bank_we    = w_cs_en & w_wr;
  assign bank_addr  = w_cs_en ? w_word_hi[BANK_AW-1:0] : '0;
  assign bank_wdata = bank_we ? icb_cmd_wdata : '0;
  assign bank_wem   = bank_we ? icb_cmd_wmask : '0;

  assign icb_cmd_ready = r_rdy_en & (r_occ < (PTR_W+1)'(OUTS));
  assign w_pop         = icb_rsp_valid & icb_rsp_ready;

  always_comb begin
    w_ent      = '0;
    w_ent.read = icb_cmd_read;
    w_ent.err  = w_oor ? ICB_ERR_DECODE : ICB_ERR_OK;
    w_ent.bank = w_bank;
    w_ent.cnt  = delay_select;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_occ    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_acc && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (!w_acc && w_pop) r_occ <= r_occ - 1'b1;
    end
  end

  e603_icb_sram_rspq #(
    .DW    (DW),
    .BANKS (BANKS),
    .OUTS  (OUTS)
  ) u_rspq (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_acc),
    .i_push_ent   (w_ent),
    .i_pop        (w_pop),
    .i_bank_rdata (bank_rdata),
    .o_head_rdy   (w_head_rdy),
    .o_head_rdata (w_head_rdata),
    .o_head_err   (w_head_err)
  );

  assign icb_rsp_valid = (r_occ != '0) & w_head_rdy;
  assign icb_rsp_rdata = icb_rsp_valid ? w_head_rdata : '0;
  assign icb_rsp_err   = icb_rsp_valid & w_head_err;

endmodule
